prf_param: RTL and testbench
============================

# prf_param

Parametrised physical register file with integrated ready-bit scoreboard for the out-of-order back end. It provides NREAD combinational read ports with optional same-cycle writeback bypass, NWRITE writeback ports, NALLOC rename-time allocation ports that clear ready bits, a flush that restores the scoreboard, and architectural HI/LO registers written by the MDU. It sits between rename/dispatch, which uses the allocation and ready lookups, and the issue/execute stages, which use the read and writeback ports.

## Interface
- PRF_NUM, 64: number of physical registers; must be a power of 2, at least 4.
- PRF_NUM_WIDTH, $clog2(PRF_NUM): physical register number width.
- NREAD, 10: read ports (2 per FU: ALU0, ALU1, BRU, LSU, MDU).
- NWRITE, 4: writeback ports (ALU0, ALU1, BRU, LSU).
- NALLOC, 2: rename allocation ports.
- NRDY, 4: ready-lookup ports (2 per renamed instruction).
- BYPASS, 1: 1 means writeback data/ready are forwarded to reads in the same cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rnum  in  NREAD*PRF_NUM_WIDTH  read numbers; port i occupies slice i.
- rdata  out  NREAD*32  read data; combinational.
- wen  in  NWRITE  writeback enables.
- wnum  in  NWRITE*PRF_NUM_WIDTH  writeback numbers.
- wdata  in  NWRITE*32  writeback data.
- alloc_en  in  NALLOC  allocation valid.
- alloc_num  in  NALLOC*PRF_NUM_WIDTH  newly allocated destination registers.
- rdy_num  in  NRDY*PRF_NUM_WIDTH  ready-lookup numbers.
- rdy  out  NRDY  ready bits; combinational.
- flush  in  1  pipeline flush (mispredict/exception).
- wen_hilo  in  1  MDU writes HI and LO.
- wdata_hi  in  32  HI write data.
- wdata_lo  in  32  LO write data.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
Register 0:
- Physical register 0 is hardwired to zero and is always ready.
- Writes and allocations to register 0 are ignored.

Reset (rst_n=0 at a clock edge):
- All data entries become 0 and all ready bits become 1.
- HI and LO become 0.
- Reset overrides every other input in the same cycle.
- Reset asserted mid-operation discards all pending state.

Writeback:
- When wen[k] is high, wdata[k] is written to entry wnum[k] and its ready bit is set.
- If several ports write the same number in one cycle, the highest-index port wins for data; ready is set.

Allocation:
- When alloc_en[j] is high, the ready bit of alloc_num[j] is cleared. Data is untouched.
- Allocation and writeback to the same number in one cycle: the allocation wins, so ready ends at 0 and the data is still written.

Flush:
- All ready bits are set to 1.
- Flush overrides allocation in the same cycle.
- Writebacks in the same cycle still write their data.
- Data entries are otherwise unchanged.

Read:
- rdata[i] = entry[rnum[i]], or 0 for number 0.
- With BYPASS=1, a same-cycle wen[k] with wnum[k]==rnum[i] (nonzero) forwards wdata[k]. The highest-index matching port wins.
- With BYPASS=0, reads return the pre-edge value.

Ready lookup:
- rdy[m] = ready[rdy_num[m]].
- With BYPASS=1, it is also 1 when a same-cycle writeback targets that number.
- Same-cycle allocations are not reflected; rename resolves intra-group dependencies itself.

HI/LO:
- When wen_hilo is high, HI and LO load wdata_hi and wdata_lo at the edge.
- hi and lo show the registered values; there is no bypass.

## Timing
- Read and ready lookups: zero-cycle combinational paths.
- Writeback data is visible via bypass in the same cycle when BYPASS=1. Without bypass it is visible on the cycle after the edge.
- Ready cleared by allocation reads 0 from the cycle after the edge.
- Flush takes effect at the edge; all rdy outputs are 1 on the next cycle.
- HI/LO update one cycle after wen_hilo.
- There is no handshake and no backpressure; every port is accepted every cycle.

## Test plan
- Reset then read: drive rst_n=0 for one edge, then read all numbers -> every rdata=0, every rdy=1, hi=lo=0.
- Allocate then write back: allocate p5 -> next cycle rdy(p5)=0. Write 0xDEADBEEF to p5 -> same cycle with BYPASS=1, rdata(p5)=0xDEADBEEF and rdy=1. Next cycle the same values come from storage.
- Port conflict: ports 0 and 3 both write p9 in one cycle with 0x11 and 0x33 -> rdata(p9)=0x33. Allocate and write back p12 in the same cycle -> rdy(p12)=0 and data holds the written value.
- Register 0: write 0xFFFFFFFF to p0 and allocate p0 -> rdata(p0)=0 and rdy(p0)=1 on every port.
- Flush: allocate p20 and p21, then on a later cycle assert flush with a new alloc of p22 -> rdy of p20, p21, p22 are all 1 after the edge.
- HI/LO and BYPASS=0 build: wen_hilo with 0x1/0x2 -> hi=1, lo=2 the next cycle. In a BYPASS=0 build, writing p3 -> the old value is read the same cycle and the new value the next cycle.

Source files
------------

// File: rtl/prf_param_if.sv
// Bundle of all read, writeback, allocation, ready-lookup, flush and HI/LO
// signals of the physical register file, with producer/consumer modports.
interface prf_param_if #(
  parameter int PRF_NUM       = 64,
  parameter int PRF_NUM_WIDTH = $clog2(PRF_NUM),
  parameter int NREAD         = 10,
  parameter int NWRITE        = 4,
  parameter int NALLOC        = 2,
  parameter int NRDY          = 4
);
  // No handshake: there is no valid/ready pair and no backpressure. Every
  // port is sampled every cycle; an enable bit qualifies each write/alloc.
  logic [NREAD*PRF_NUM_WIDTH-1:0]  rnum;
  logic [NREAD*32-1:0]             rdata;
  logic [NWRITE-1:0]               wen;
  logic [NWRITE*PRF_NUM_WIDTH-1:0] wnum;
  logic [NWRITE*32-1:0]            wdata;
  logic [NALLOC-1:0]               alloc_en;
  logic [NALLOC*PRF_NUM_WIDTH-1:0] alloc_num;
  logic [NRDY*PRF_NUM_WIDTH-1:0]   rdy_num;
  logic [NRDY-1:0]                 rdy;
  logic                            flush;
  logic                            wen_hilo;
  logic [31:0]                     wdata_hi;
  logic [31:0]                     wdata_lo;
  logic [31:0]                     hi;
  logic [31:0]                     lo;

  modport master (
    output rnum, wen, wnum, wdata, alloc_en, alloc_num, rdy_num,
           flush, wen_hilo, wdata_hi, wdata_lo,
    input  rdata, rdy, hi, lo
  );

  modport slave (
    input  rnum, wen, wnum, wdata, alloc_en, alloc_num, rdy_num,
           flush, wen_hilo, wdata_hi, wdata_lo,
    output rdata, rdy, hi, lo
  );
endinterface

// File: rtl/prf_param.sv
// Physical register file with ready-bit scoreboard, optional writeback bypass
// on reads/ready lookups, and MDU-written HI/LO registers.
module prf_param #(
  parameter int PRF_NUM       = 64,
  parameter int PRF_NUM_WIDTH = $clog2(PRF_NUM),
  parameter int NREAD         = 10,
  parameter int NWRITE        = 4,
  parameter int NALLOC        = 2,
  parameter int NRDY          = 4,
  parameter int BYPASS        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  prf_param_if.slave  bus
);
  localparam int W = PRF_NUM_WIDTH;
  typedef logic [W-1:0] pnum_t;

  logic [31:0]        data_q [PRF_NUM];
  logic [31:0]        data_d [PRF_NUM];
  logic [PRF_NUM-1:0] ready_q, ready_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  // Writes are applied in ascending port order so the highest port wins;
  // allocation clears ready after writeback sets it, and flush beats both.
  always_comb begin : next_state
    data_d  = data_q;
    ready_d = ready_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (bus.wen[k]) begin
        data_d[bus.wnum[k*W +: W]]  = bus.wdata[k*32 +: 32];
        ready_d[bus.wnum[k*W +: W]] = 1'b1;
      end
    end
    if (bus.flush) begin
      ready_d = '1;
    end else begin
      for (int j = 0; j < NALLOC; j++) begin
        if (bus.alloc_en[j]) ready_d[bus.alloc_num[j*W +: W]] = 1'b0;
      end
    end
    data_d[0]  = '0;
    ready_d[0] = 1'b1;
    hi_d = bus.wen_hilo ? bus.wdata_hi : hi_q;
    lo_d = bus.wen_hilo ? bus.wdata_lo : lo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < PRF_NUM; n++) data_q[n] <= '0;
      ready_q <= '1;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      for (int n = 0; n < PRF_NUM; n++) data_q[n] <= data_d[n];
      ready_q <= ready_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin : read_ports
    pnum_t       rn;
    logic [31:0] rv;
    rn        = '0;
    rv        = '0;
    bus.rdata = '0;
    for (int i = 0; i < NREAD; i++) begin
      rn = bus.rnum[i*W +: W];
      rv = data_q[rn];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWRITE; k++) begin
          if (bus.wen[k] && (bus.wnum[k*W +: W] == rn)) rv = bus.wdata[k*32 +: 32];
        end
      end
      if (rn == '0) rv = '0;
      bus.rdata[i*32 +: 32] = rv;
    end
  end

  // Same-cycle allocations are deliberately invisible here; rename resolves
  // intra-group dependencies itself.
  always_comb begin : ready_ports
    pnum_t rn;
    logic  rr;
    rn      = '0;
    rr      = 1'b0;
    bus.rdy = '0;
    for (int m = 0; m < NRDY; m++) begin
      rn = bus.rdy_num[m*W +: W];
      rr = ready_q[rn];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWRITE; k++) begin
          if (bus.wen[k] && (bus.wnum[k*W +: W] == rn)) rr = 1'b1;
        end
      end
      bus.rdy[m] = rr;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_prf_param.sv
// Bench for prf_param: constant-vector table, hand sequences for HI/LO, reset
// and the no-bypass build, then random traffic against an entry-wise model.
module tb_prf_param;
  localparam int PN = 64;
  localparam int PW = 6;
  localparam int NR = 10;
  localparam int NW = 4;
  localparam int NA = 2;
  localparam int NY = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prf_param_if #(.PRF_NUM(PN), .PRF_NUM_WIDTH(PW), .NREAD(NR), .NWRITE(NW),
                 .NALLOC(NA), .NRDY(NY)) bus1 ();
  prf_param_if #(.PRF_NUM(PN), .PRF_NUM_WIDTH(PW), .NREAD(NR), .NWRITE(NW),
                 .NALLOC(NA), .NRDY(NY)) bus0 ();

  prf_param #(.PRF_NUM(PN), .PRF_NUM_WIDTH(PW), .NREAD(NR), .NWRITE(NW),
              .NALLOC(NA), .NRDY(NY), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  prf_param #(.PRF_NUM(PN), .PRF_NUM_WIDTH(PW), .NREAD(NR), .NWRITE(NW),
              .NALLOC(NA), .NRDY(NY), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  // driver-side copies of the bypass DUT's inputs
  logic          t_wen   [NW];
  logic [PW-1:0] t_wnum  [NW];
  logic [31:0]   t_wdata [NW];
  logic          t_aen   [NA];
  logic [PW-1:0] t_anum  [NA];
  logic [PW-1:0] t_rnum  [NR];
  logic [PW-1:0] t_rdyn  [NY];
  logic          t_flush, t_hilo;
  logic [31:0]   t_whi, t_wlo;

  // reference model
  logic [31:0] m_data [PN];
  logic        m_rdy  [PN];
  logic [31:0] m_hi, m_lo;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic          w0_en; logic [PW-1:0] w0_num; logic [31:0] w0_data;
    logic          w3_en; logic [PW-1:0] w3_num; logic [31:0] w3_data;
    logic          a0_en; logic [PW-1:0] a0_num;
    logic          a1_en; logic [PW-1:0] a1_num;
    logic          flush;
    logic [PW-1:0] probe;
    logic [31:0]   exp_data;
    logic          exp_rdy;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NW; k++) begin t_wen[k] = 0; t_wnum[k] = '0; t_wdata[k] = '0; end
    for (int j = 0; j < NA; j++) begin t_aen[j] = 0; t_anum[j] = '0; end
    for (int i = 0; i < NR; i++) t_rnum[i] = '0;
    for (int m = 0; m < NY; m++) t_rdyn[m] = '0;
    t_flush = 0; t_hilo = 0; t_whi = '0; t_wlo = '0;
  endtask

  task automatic drive();
    for (int k = 0; k < NW; k++) begin
      bus1.wen[k] = t_wen[k];
      bus1.wnum[k*PW +: PW] = t_wnum[k];
      bus1.wdata[k*32 +: 32] = t_wdata[k];
    end
    for (int j = 0; j < NA; j++) begin
      bus1.alloc_en[j] = t_aen[j];
      bus1.alloc_num[j*PW +: PW] = t_anum[j];
    end
    for (int i = 0; i < NR; i++) bus1.rnum[i*PW +: PW] = t_rnum[i];
    for (int m = 0; m < NY; m++) bus1.rdy_num[m*PW +: PW] = t_rdyn[m];
    bus1.flush = t_flush; bus1.wen_hilo = t_hilo;
    bus1.wdata_hi = t_whi; bus1.wdata_lo = t_wlo;
  endtask

  function automatic logic [31:0] exp_read(input logic [PW-1:0] n);
    logic [31:0] v;
    v = m_data[n];
    for (int k = 0; k < NW; k++) if (t_wen[k] && t_wnum[k] == n) v = t_wdata[k];
    return (n == 0) ? 32'h0 : v;
  endfunction

  function automatic logic exp_rdy(input logic [PW-1:0] n);
    logic r;
    r = m_rdy[n];
    for (int k = 0; k < NW; k++) if (t_wen[k] && t_wnum[k] == n) r = 1'b1;
    return (n == 0) ? 1'b1 : r;
  endfunction

  // Entry-by-entry update: decide what happened to each register this edge.
  task automatic model_edge();
    logic wr, alc;
    logic [31:0] nd;
    if (!rst_n) begin
      for (int n = 0; n < PN; n++) begin m_data[n] = '0; m_rdy[n] = 1'b1; end
      m_hi = '0; m_lo = '0;
      return;
    end
    for (int n = 1; n < PN; n++) begin
      wr = 0; alc = 0; nd = '0;
      for (int k = 0; k < NW; k++) if (t_wen[k] && t_wnum[k] == PW'(n)) begin wr = 1; nd = t_wdata[k]; end
      for (int j = 0; j < NA; j++) if (t_aen[j] && t_anum[j] == PW'(n)) alc = 1;
      if (wr) m_data[n] = nd;
      m_rdy[n] = t_flush ? 1'b1 : alc ? 1'b0 : wr ? 1'b1 : m_rdy[n];
    end
    if (t_hilo) begin m_hi = t_whi; m_lo = t_wlo; end
  endtask

  task automatic check_model();
    for (int i = 0; i < NR; i++)
      chk($sformatf("model rdata[%0d] p%0d", i, t_rnum[i]), bus1.rdata[i*32 +: 32], exp_read(t_rnum[i]));
    for (int m = 0; m < NY; m++)
      chk($sformatf("model rdy[%0d] p%0d", m, t_rdyn[m]), {31'b0, bus1.rdy[m]}, {31'b0, exp_rdy(t_rdyn[m])});
    chk("model hi", bus1.hi, m_hi);
    chk("model lo", bus1.lo, m_lo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Reset (optionally with traffic in the same cycle), then sweep every number.
  task automatic reset_sweep(input bit traffic);
    clear_inputs();
    if (traffic) begin
      t_wen[1] = 1; t_wnum[1] = 6'd5; t_wdata[1] = 32'h5555_5555;
      t_aen[0] = 1; t_anum[0] = 6'd6;
      t_hilo = 1; t_whi = 32'h1234; t_wlo = 32'h5678;
    end
    rst_n = 1'b0;
    drive();
    tick();
    rst_n = 1'b1;
    clear_inputs();
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NR; i++) t_rnum[i] = PW'((c*NR + i) % PN);
      for (int m = 0; m < NY; m++) t_rdyn[m] = PW'(c*NY + m);
      drive();
      #1;
      for (int i = 0; i < NR; i++) chk($sformatf("reset rdata p%0d", t_rnum[i]), bus1.rdata[i*32 +: 32], 32'h0);
      for (int m = 0; m < NY; m++) chk($sformatf("reset rdy p%0d", t_rdyn[m]), {31'b0, bus1.rdy[m]}, 32'h1);
      chk("reset hi", bus1.hi, 32'h0);
      chk("reset lo", bus1.lo, 32'h0);
      tick();
    end
  endtask

  function automatic vec_t mk(input logic w0e, input int w0n, input logic [31:0] w0d,
                              input logic w3e, input int w3n, input logic [31:0] w3d,
                              input logic a0e, input int a0n, input logic a1e, input int a1n,
                              input logic fl, input int probe, input logic [31:0] ed, input logic er);
    vec_t v;
    v.w0_en = w0e; v.w0_num = PW'(w0n); v.w0_data = w0d;
    v.w3_en = w3e; v.w3_num = PW'(w3n); v.w3_data = w3d;
    v.a0_en = a0e; v.a0_num = PW'(a0n); v.a1_en = a1e; v.a1_num = PW'(a1n);
    v.flush = fl; v.probe = PW'(probe); v.exp_data = ed; v.exp_rdy = er;
    return v;
  endfunction

  initial begin
    // constant vectors: same-cycle values seen before each edge
    vecs[0]  = mk(0, 0, 0,            0, 0, 0,     1, 5,  0, 0,  0, 5,  32'h0,        1);
    vecs[1]  = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 5,  32'h0,        0);
    vecs[2]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0,  0, 0,  0, 5,  32'hDEADBEEF, 1);
    vecs[3]  = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 5,  32'hDEADBEEF, 1);
    vecs[4]  = mk(1, 9, 32'h11,       1, 9, 32'h33, 0, 0, 0, 0,  0, 9,  32'h33,       1);
    vecs[5]  = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 9,  32'h33,       1);
    vecs[6]  = mk(1, 12, 32'hABCD,    0, 0, 0,     1, 12, 0, 0,  0, 12, 32'hABCD,     1);
    vecs[7]  = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 12, 32'hABCD,     0);
    vecs[8]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,     1, 0,  0, 0,  0, 0,  32'h0,        1);
    vecs[9]  = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 0,  32'h0,        1);
    vecs[10] = mk(0, 0, 0,            0, 0, 0,     1, 20, 1, 21, 0, 20, 32'h0,        1);
    vecs[11] = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 21, 32'h0,        0);
    vecs[12] = mk(0, 0, 0,            0, 0, 0,     1, 22, 0, 0,  1, 20, 32'h0,        0);
    vecs[13] = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 20, 32'h0,        1);
    vecs[14] = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 21, 32'h0,        1);
    vecs[15] = mk(0, 0, 0,            0, 0, 0,     0, 0,  0, 0,  0, 22, 32'h0,        1);

    bus0.rnum = '0; bus0.wen = '0; bus0.wnum = '0; bus0.wdata = '0;
    bus0.alloc_en = '0; bus0.alloc_num = '0; bus0.rdy_num = '0;
    bus0.flush = 0; bus0.wen_hilo = 0; bus0.wdata_hi = '0; bus0.wdata_lo = '0;

    reset_sweep(1'b0);

    // HI/LO: no bypass, visible after the edge
    clear_inputs();
    t_hilo = 1; t_whi = 32'h1; t_wlo = 32'h2;
    drive(); #1;
    chk("hilo same-cycle hi", bus1.hi, 32'h0);
    chk("hilo same-cycle lo", bus1.lo, 32'h0);
    tick();
    clear_inputs(); drive(); #1;
    chk("hilo next hi", bus1.hi, 32'h1);
    chk("hilo next lo", bus1.lo, 32'h2);
    tick();

    for (int v = 0; v < 16; v++) begin
      clear_inputs();
      t_wen[0] = vecs[v].w0_en; t_wnum[0] = vecs[v].w0_num; t_wdata[0] = vecs[v].w0_data;
      t_wen[3] = vecs[v].w3_en; t_wnum[3] = vecs[v].w3_num; t_wdata[3] = vecs[v].w3_data;
      t_aen[0] = vecs[v].a0_en; t_anum[0] = vecs[v].a0_num;
      t_aen[1] = vecs[v].a1_en; t_anum[1] = vecs[v].a1_num;
      t_flush = vecs[v].flush;
      for (int i = 0; i < NR; i++) t_rnum[i] = vecs[v].probe;
      for (int m = 0; m < NY; m++) t_rdyn[m] = vecs[v].probe;
      drive(); #1;
      for (int i = 0; i < NR; i++)
        chk($sformatf("vec%0d rdata[%0d]", v, i), bus1.rdata[i*32 +: 32], vecs[v].exp_data);
      for (int m = 0; m < NY; m++)
        chk($sformatf("vec%0d rdy[%0d]", v, m), {31'b0, bus1.rdy[m]}, {31'b0, vecs[v].exp_rdy});
      check_model();
      tick();
    end

    // BYPASS=0 build: allocate p3, then write it; old value/ready until the edge
    bus0.alloc_en = 2'b01; bus0.alloc_num[PW-1:0] = 6'd3;
    bus0.rnum[PW-1:0] = 6'd3; bus0.rdy_num[PW-1:0] = 6'd3;
    @(posedge clk); @(negedge clk);
    bus0.alloc_en = '0;
    bus0.wen = 4'b0001; bus0.wnum[PW-1:0] = 6'd3; bus0.wdata[31:0] = 32'hA5A5_0003;
    #1;
    chk("nobyp same-cycle rdata p3", bus0.rdata[31:0], 32'h0);
    chk("nobyp same-cycle rdy p3", {31'b0, bus0.rdy[0]}, 32'h0);
    @(posedge clk); @(negedge clk);
    bus0.wen = '0;
    #1;
    chk("nobyp next rdata p3", bus0.rdata[31:0], 32'hA5A5_0003);
    chk("nobyp next rdy p3", {31'b0, bus0.rdy[0]}, 32'h1);

    // random traffic concentrated on a few numbers to force collisions
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      for (int k = 0; k < NW; k++) begin
        t_wen[k] = 1'($urandom_range(0, 1));
        t_wnum[k] = PW'($urandom_range(0, 15));
        t_wdata[k] = $urandom;
      end
      for (int j = 0; j < NA; j++) begin
        t_aen[j] = ($urandom_range(0, 2) == 0);
        t_anum[j] = PW'($urandom_range(0, 15));
      end
      t_flush = ($urandom_range(0, 19) == 0);
      t_hilo = ($urandom_range(0, 3) == 0);
      t_whi = $urandom; t_wlo = $urandom;
      for (int i = 0; i < NR; i++) t_rnum[i] = PW'($urandom_range(0, (c % 8 == 0) ? PN-1 : 15));
      for (int m = 0; m < NY; m++) t_rdyn[m] = PW'($urandom_range(0, 15));
      drive(); #1;
      check_model();
      tick();
    end

    reset_sweep(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
